st2cl_post_afu: RTL and testbench
=================================

// Module: st2cl_post_afu
// PURPOSE
//  Packs a framed Avalon-ST sample stream (ST-bit samples, sop/eop/valid/ready) into CL-bit cache lines.
//  Each line carries a CL_HEAD-bit head and CL_PAYLOAD bits of payload, written into the AFU-bound FIFO.
//  Inverse of the cache-line -> stream unpacker. Sits between the stream source and the upstream AFU FIFO.
// PARAMETERS
//  CL            512  cache-line width, bits
//  CL_HEAD       16   head width, bits
//  CL_PAYLOAD    496  payload width, bits (CL - CL_HEAD)
//  ST            12   stream sample width, bits
//  w_len_CLHead  10   width of the length field in the head
//  (localparam SPL = CL_PAYLOAD/ST = 41, samples per line)
// PORTS
//  clk             in   1       clock
//  rst_n           in   1       asynchronous reset, active low
//  sink_data       in   ST      sample
//  sink_valid      in   1       sample valid
//  sink_sop        in   1       first sample of frame
//  sink_eop        in   1       last sample of frame
//  sink_ready      out  1       block can accept a sample
//  ff_almost_full  in   1       FIFO has <=3 free entries
//  ff_wrreq        out  1       FIFO write strobe, one line per cycle
//  ff_data         out  CL      cache line to FIFO
//  ff_wr_finish    out  1       1-cycle pulse, coincident with ff_wrreq of a frame's last line
//  frame_err       out  1       1-cycle pulse on a protocol error (see below)
// BEHAVIOUR
//  Reset: sink_ready=0, ff_wrreq=0, ff_data=0, ff_wr_finish=0, frame_err=0, state=IDLE, count=0.
//  Reset mid-frame discards the partial line; nothing is written.
//  Accept = sink_valid & sink_ready. sink_ready is registered: sink_ready <= !ff_almost_full.
//  Line layout:
//   head[9:0]   = number of valid samples, 1..SPL
//   head[12:10] = 0
//   head[13]    = error
//   head[14]    = first line of frame
//   head[15]    = last line of frame
//   sample k at ff_data[CL_HEAD+ST*k +: ST], k = 0..count-1
//   unused slots and pad bits [CL-1:CL_HEAD+ST*SPL] = 0
//  FSM IDLE/PACK:
//   IDLE:
//    - accept with sop: store at slot 0, count=1, first flag set, go to PACK
//    - accept without sop: drop sample, pulse frame_err, stay in IDLE
//   PACK:
//    - accept without sop: store at slot count, count+1
//  Line emit: on the accept edge that fills slot SPL-1, or that carries eop:
//   - ff_data is loaded with the completed line; ff_wrreq=1 the next cycle (latency 1); count resets to 0
//   - eop also sets head[15], pulses ff_wr_finish with ff_wrreq, and returns the FSM to IDLE
//   - SPL-th sample with eop: one line only, flagged last; no empty line follows
//   - first flag is set only on the first line of a frame
//  sop & eop on the same beat: single-sample frame, one line, head = first|last|len 1.
//  sop accepted while in PACK:
//   - the partial line (if count>0) is emitted with last=1, err=1; ff_wr_finish=0; frame_err pulses
//   - the sop sample opens a new frame at slot 0 on the same edge; no sample is lost
//  Back-to-back lines: one emit per cycle max, no bubbles while the stream is continuous.
//  ff_wrreq is never issued for an empty line.
//  ff_almost_full is sampled only via sink_ready; the 3-entry margin absorbs the in-flight line.
// TESTING
//  1 41-sample frame, values 1..41 -> one line, head=0xC029, slot k = k+1, pad=0, ff_wr_finish=1
//  2 100-sample frame -> 3 lines, heads 0x4029, 0x0029, 0x8012; ff_wr_finish only with the 3rd line
//  3 sop&eop single sample 0xABC -> head=0xC001, ff_data[27:16]=0xABC, all other bits 0
//  4 ff_almost_full high at sample 20 for 10 cycles -> sink_ready low 1 cycle later, no loss/dup; lines match ref model
//  5 sop at sample 11 of open frame -> line head=0xE00A, frame_err pulse; new frame packs normally from slot 0
//  6 rst_n low mid-frame (count=25) -> no ff_wrreq; all outputs 0; next frame after reset starts with first flag set
//  7 valid without sop in IDLE -> frame_err pulse, sample dropped, no write

Source files
------------

// File: rtl/st2cl_post_afu_if.sv
// Stream-side and FIFO-side signals of the stream-to-cache-line packer.
// The master drives samples and FIFO status. The slave (the packer) drives ready, lines and status.
interface st2cl_post_afu_if #(
  parameter int CL = 512,
  parameter int ST = 12
);
  logic [ST-1:0] sink_data;
  logic          sink_valid;
  logic          sink_sop;
  logic          sink_eop;
  logic          sink_ready;
  logic          ff_almost_full;
  logic          ff_wrreq;
  logic [CL-1:0] ff_data;
  logic          ff_wr_finish;
  logic          frame_err;

  modport master (
    output sink_data, sink_valid, sink_sop, sink_eop, ff_almost_full,
    input  sink_ready, ff_wrreq, ff_data, ff_wr_finish, frame_err
  );

  modport slave (
    input  sink_data, sink_valid, sink_sop, sink_eop, ff_almost_full,
    output sink_ready, ff_wrreq, ff_data, ff_wr_finish, frame_err
  );
endinterface

// File: rtl/st2cl_post_afu.sv
// Packs a framed Avalon-ST sample stream into cache lines: a 16-bit head
// (length/err/first/last) followed by up to SPL samples, one line per FIFO write.
module st2cl_post_afu #(
  parameter int CL         = 512,
  parameter int CL_HEAD    = 16,
  parameter int CL_PAYLOAD = CL - CL_HEAD,
  parameter int ST         = 12,
  parameter int W_LEN      = 10
) (
  input  logic clk,
  input  logic rst_n,
  st2cl_post_afu_if.slave bus
);
  localparam int SPL   = CL_PAYLOAD / ST;
  localparam int PAY_W = ST * SPL;

  typedef enum logic {S_IDLE, S_PACK} state_t;

  state_t             r_state, w_next_state;
  logic [W_LEN-1:0]   r_count, w_next_count, w_cnt1, w_e_len;
  logic [PAY_W-1:0]   r_payload, w_next_payload, w_full_pay, w_e_pay;
  logic               r_first, w_next_first;
  logic               r_pend, w_set_pend;
  logic               r_sink_ready;
  logic               r_vld_p1, r_fin_p1, r_ferr_p1;
  logic [CL-1:0]      r_line_p1, w_line;
  logic               w_acc, w_emit, w_e_first, w_e_last, w_e_err, w_ferr;

  function automatic logic [PAY_W-1:0] place(input logic [ST-1:0] s, input logic [W_LEN-1:0] k);
    logic [PAY_W-1:0] v;
    v = '0;
    v[ST-1:0] = s;
    return v << (ST * k);
  endfunction

  function automatic logic [CL_HEAD-1:0] make_head(input logic [W_LEN-1:0] len,
                                                   input logic err, input logic first,
                                                   input logic last);
    logic [CL_HEAD-1:0] h;
    h = '0;
    h[W_LEN-1:0]   = len;
    h[CL_HEAD-3]   = err;
    h[CL_HEAD-2]   = first;
    h[CL_HEAD-1]   = last;
    return h;
  endfunction

  assign w_acc      = bus.sink_valid & r_sink_ready;
  assign w_cnt1     = r_count + W_LEN'(1);
  assign w_full_pay = r_payload | place(bus.sink_data, r_count);

  always_comb begin
    w_next_state   = r_state;
    w_next_count   = r_count;
    w_next_payload = r_payload;
    w_next_first   = r_first;
    w_set_pend     = 1'b0;
    w_emit         = 1'b0;
    w_e_len        = '0;
    w_e_pay        = '0;
    w_e_first      = 1'b0;
    w_e_last       = 1'b0;
    w_e_err        = 1'b0;
    w_ferr         = 1'b0;
    if (r_pend) begin
      // Deferred single-sample frame that collided with an error-line emit.
      w_emit         = 1'b1;
      w_e_len        = r_count;
      w_e_pay        = r_payload;
      w_e_first      = r_first;
      w_e_last       = 1'b1;
      w_next_state   = S_IDLE;
      w_next_count   = '0;
      w_next_payload = '0;
      w_next_first   = 1'b0;
    end else if (w_acc) begin
      if (bus.sink_sop) begin
        if (r_state == S_PACK) begin
          w_ferr = 1'b1;
          if (r_count != '0) begin
            w_emit    = 1'b1;
            w_e_len   = r_count;
            w_e_pay   = r_payload;
            w_e_first = r_first;
            w_e_last  = 1'b1;
            w_e_err   = 1'b1;
          end
        end
        w_next_state   = S_PACK;
        w_next_count   = W_LEN'(1);
        w_next_payload = place(bus.sink_data, '0);
        w_next_first   = 1'b1;
        if (bus.sink_eop) begin
          if (w_emit) begin
            w_set_pend = 1'b1;
          end else begin
            w_emit         = 1'b1;
            w_e_len        = W_LEN'(1);
            w_e_pay        = place(bus.sink_data, '0);
            w_e_first      = 1'b1;
            w_e_last       = 1'b1;
            w_next_state   = S_IDLE;
            w_next_count   = '0;
            w_next_payload = '0;
            w_next_first   = 1'b0;
          end
        end
      end else if (r_state == S_IDLE) begin
        w_ferr = 1'b1;
      end else if (bus.sink_eop || (w_cnt1 == W_LEN'(SPL))) begin
        w_emit         = 1'b1;
        w_e_len        = w_cnt1;
        w_e_pay        = w_full_pay;
        w_e_first      = r_first;
        w_e_last       = bus.sink_eop;
        w_next_count   = '0;
        w_next_payload = '0;
        w_next_first   = 1'b0;
        if (bus.sink_eop) w_next_state = S_IDLE;
      end else begin
        w_next_count   = w_cnt1;
        w_next_payload = w_full_pay;
      end
    end
  end

  always_comb begin
    w_line = '0;
    w_line[CL_HEAD-1:0]      = make_head(w_e_len, w_e_err, w_e_first, w_e_last);
    w_line[CL_HEAD +: PAY_W] = w_e_pay;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_payload <= '0;
      r_first   <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_count   <= w_next_count;
      r_payload <= w_next_payload;
      r_first   <= w_next_first;
      r_pend    <= w_set_pend;
    end
  end

  // Output stage: completed line presented one cycle after its accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sink_ready <= 1'b0;
      r_vld_p1     <= 1'b0;
      r_line_p1    <= '0;
      r_fin_p1     <= 1'b0;
      r_ferr_p1    <= 1'b0;
    end else begin
      r_sink_ready <= !bus.ff_almost_full && !w_set_pend;
      r_vld_p1     <= w_emit;
      if (w_emit) r_line_p1 <= w_line;
      r_fin_p1     <= w_emit & w_e_last & !w_e_err;
      r_ferr_p1    <= w_ferr;
    end
  end

  assign bus.sink_ready   = r_sink_ready;
  assign bus.ff_wrreq     = r_vld_p1;
  assign bus.ff_data      = r_line_p1;
  assign bus.ff_wr_finish = r_fin_p1;
  assign bus.frame_err    = r_ferr_p1;
endmodule

// File: tb/tb_st2cl_post_afu.sv
// Scoreboard bench for st2cl_post_afu: a queue-based frame model predicts every
// written line; a negedge monitor pops and compares each FIFO write.
module tb_st2cl_post_afu;
  localparam int CL  = 512;
  localparam int ST  = 12;
  localparam int SPL = 41;

  typedef struct packed {
    logic [CL-1:0] d;
    logic          fin;
  } line_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  st2cl_post_afu_if #(.CL(CL), .ST(ST)) bus();
  st2cl_post_afu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0, n_fail = 0, exp_ferr = 0, obs_ferr = 0;
  line_t         exp_q[$];
  line_t         mon_e;
  logic [15:0]   heads_q[$];
  logic [ST-1:0] cur[$];
  bit            in_frame = 0, first_line = 0, rnd_on = 0;

  function automatic void chk(string name, logic [CL-1:0] act, logic [CL-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endfunction

  // Reference: a line is the current sample list plus head flags.
  function automatic void push_line(bit err, bit last);
    line_t e;
    e.d = '0;
    e.d[9:0] = 10'(cur.size());
    e.d[13]  = err;
    e.d[14]  = first_line;
    e.d[15]  = last;
    foreach (cur[k]) e.d[16 + ST*k +: ST] = cur[k];
    e.fin = last && !err;
    exp_q.push_back(e);
    cur.delete();
    first_line = 0;
  endfunction

  function automatic void model_accept(logic [ST-1:0] s, bit sop, bit eop);
    if (sop) begin
      if (in_frame) begin
        exp_ferr++;
        if (cur.size() > 0) push_line(1, 1);
      end
      cur.delete();
      cur.push_back(s);
      first_line = 1;
      in_frame   = 1;
    end else if (!in_frame) begin
      exp_ferr++;
      return;
    end else begin
      cur.push_back(s);
    end
    if (eop) begin
      push_line(0, 1);
      in_frame = 0;
    end else if (cur.size() == SPL) begin
      push_line(0, 0);
    end
  endfunction

  always @(negedge clk) begin
    if (bus.ff_wrreq === 1'b1) begin
      heads_q.push_back(bus.ff_data[15:0]);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: head %0h, no line expected", bus.ff_data[15:0]);
      end else begin
        mon_e = exp_q.pop_front();
        chk("line_data", bus.ff_data, mon_e.d);
        chk("wr_finish", CL'(bus.ff_wr_finish), CL'(mon_e.fin));
      end
    end else if (bus.ff_wr_finish !== 1'b0) begin
      chk("finish_without_wrreq", CL'(bus.ff_wr_finish), '0);
    end
    if (bus.frame_err === 1'b1) obs_ferr++;
  end

  task automatic idle(int n);
    bus.sink_valid = 1'b0;
    bus.sink_sop   = 1'b0;
    bus.sink_eop   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [ST-1:0] s, bit sop, bit eop);
    int w;
    w = 0;
    bus.sink_data  = s;
    bus.sink_valid = 1'b1;
    bus.sink_sop   = sop;
    bus.sink_eop   = eop;
    forever begin
      @(negedge clk);
      if (bus.sink_ready === 1'b1) begin
        model_accept(s, sop, eop);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      w++;
      if (w > 200) begin
        chk("ready_timeout", CL'(bus.sink_ready), CL'(1));
        break;
      end
    end
  endtask

  task automatic send_frame(int len, int gapmax, bit rnd, bit close);
    for (int i = 0; i < len; i++) begin
      send(rnd ? 12'($urandom) : 12'(i + 1), i == 0, close && (i == len - 1));
      if (gapmax > 0) begin
        int g;
        g = $urandom_range(0, gapmax);
        if (g > 0) idle(g);
      end
    end
    bus.sink_valid = 1'b0;
  endtask

  task automatic drain(string name);
    idle(4);
    chk({name, "_pending_lines"}, CL'(exp_q.size()), '0);
    chk({name, "_frame_err_count"}, CL'(obs_ferr), CL'(exp_ferr));
  endtask

  task automatic chk_head(int idx, logic [15:0] v);
    if (idx < heads_q.size()) chk("head", CL'(heads_q[idx]), CL'(v));
    else chk("head_missing", CL'(heads_q.size()), CL'(idx + 1));
  endtask

  initial begin
    bus.sink_data      = '0;
    bus.sink_valid     = 1'b0;
    bus.sink_sop       = 1'b0;
    bus.sink_eop       = 1'b0;
    bus.ff_almost_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sink_ready", CL'(bus.sink_ready), '0);
    chk("rst_wrreq", CL'(bus.ff_wrreq), '0);
    chk("rst_data", bus.ff_data, '0);
    chk("rst_finish", CL'(bus.ff_wr_finish), '0);
    chk("rst_frame_err", CL'(bus.frame_err), '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 41-sample frame fills exactly one line
    heads_q.delete();
    send_frame(41, 0, 0, 1);
    drain("t1");
    chk("t1_lines", CL'(heads_q.size()), CL'(1));
    chk_head(0, 16'hC029);

    // 100-sample frame spans three lines
    heads_q.delete();
    send_frame(100, 0, 0, 1);
    drain("t2");
    chk("t2_lines", CL'(heads_q.size()), CL'(3));
    chk_head(0, 16'h4029);
    chk_head(1, 16'h0029);
    chk_head(2, 16'h8012);

    // single-sample frame
    heads_q.delete();
    send(12'hABC, 1, 1);
    drain("t3");
    chk_head(0, 16'hC001);

    // FIFO almost full at sample 20 for 10 cycles
    heads_q.delete();
    for (int i = 0; i < 60; i++) begin
      if (i == 19) begin
        bus.ff_almost_full = 1'b1;
        fork
          begin
            @(negedge clk);
            chk("t4_ready_still_high", CL'(bus.sink_ready), CL'(1));
            @(negedge clk);
            chk("t4_ready_low", CL'(bus.sink_ready), '0);
            repeat (9) @(posedge clk);
            #1 bus.ff_almost_full = 1'b0;
          end
        join_none
      end
      send(12'($urandom), i == 0, i == 59);
    end
    drain("t4");
    chk("t4_lines", CL'(heads_q.size()), CL'(2));

    // sop arriving at sample 11 of an open frame
    heads_q.delete();
    send_frame(10, 0, 1, 0);
    send_frame(5, 0, 1, 1);
    drain("t5");
    chk_head(0, 16'hE00A);
    chk_head(1, 16'hC005);

    // valid without sop while idle
    heads_q.delete();
    send(12'h123, 0, 0);
    drain("t7");
    chk("t7_no_write", CL'(heads_q.size()), '0);

    // reset in the middle of a frame
    heads_q.delete();
    send_frame(25, 0, 1, 0);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ready", CL'(bus.sink_ready), '0);
    chk("t6_wrreq", CL'(bus.ff_wrreq), '0);
    chk("t6_data", bus.ff_data, '0);
    chk("t6_finish", CL'(bus.ff_wr_finish), '0);
    cur.delete();
    in_frame = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_no_write_in_reset", CL'(heads_q.size()), '0);
    send_frame(3, 0, 1, 1);
    drain("t6");
    chk_head(0, 16'hC003);

    // randomized frames with gaps, errors and back-pressure
    rnd_on = 1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #2 bus.ff_almost_full = ($urandom_range(0, 7) == 0);
        end
        bus.ff_almost_full = 1'b0;
      end
    join_none
    for (int f = 0; f < 30; f++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) send(12'($urandom), 0, $urandom_range(0, 1) == 1);
      else if (kind == 1) send_frame($urandom_range(1, 60), 1, 1, 0);
      else send_frame($urandom_range(1, 130), $urandom_range(0, 2), 1, 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    send_frame(4, 0, 1, 1);
    rnd_on = 0;
    idle(3);
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
